// File: rtl/sonar_filter_pkg.sv
// Shared types and default constants for the sonar distance filter.
package sonar_filter_pkg;

  typedef enum logic {
    FILL,
    RUN
  } filter_state_e;

  localparam int unsigned DEF_DATA_WIDTH    = 16;
  localparam int unsigned DEF_WINDOW_LOG2   = 2;
  localparam int unsigned DEF_NEAR_THRESH   = 200;
  localparam int unsigned DEF_FAR_THRESH    = 300;
  localparam int unsigned DEF_DEBOUNCE      = 3;
  localparam int unsigned DEF_TIMEOUT_WIDTH = 23;

  // Wide enough to hold a full window of all-ones samples.
  function automatic int unsigned sum_width(input int unsigned data_width,
                                            input int unsigned window_log2);
    return data_width + window_log2;
  endfunction

endpackage

// File: rtl/window_delay_line.sv
// Shift register holding the most recent 2^DEPTH_LOG2 samples; exposes the oldest.
module window_delay_line #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] oldest
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] taps_q [DEPTH];
  logic [DATA_WIDTH-1:0] taps_d [DEPTH];

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    taps_d = taps_q;
    if (clear) begin
      taps_d = '{default: '0};
    end else if (push) begin
      taps_d[0] = data_in;
      for (int i = 1; i < DEPTH; i++) begin
        taps_d[i] = taps_q[i-1];
      end
    end
  end

  // NOTE: this storage is reset on purpose: the running sum subtracts evicted
  // entries and relies on empty slots reading as zero while the window fills.
  always_ff @(posedge clk) begin
    if (reset) begin
      taps_q <= '{default: '0};
    end else begin
      taps_q <= taps_d;
    end
  end

  assign oldest = taps_q[DEPTH-1];

endmodule

// File: rtl/sonar_distance_filter.sv
// Moving-average filter for echo samples with debounced hysteretic presence
// detection and a stale-sensor watchdog that flushes the window.
module sonar_distance_filter
  import sonar_filter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned WINDOW_LOG2   = DEF_WINDOW_LOG2,
  parameter int unsigned NEAR_THRESH   = DEF_NEAR_THRESH,
  parameter int unsigned FAR_THRESH    = DEF_FAR_THRESH,
  parameter int unsigned DEBOUNCE      = DEF_DEBOUNCE,
  parameter int unsigned TIMEOUT_WIDTH = DEF_TIMEOUT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  output logic [DATA_WIDTH-1:0] avg_out,
  output logic                  avg_valid,
  output logic                  present,
  output logic                  stale
);

  localparam int unsigned SUM_W  = sum_width(DATA_WIDTH, WINDOW_LOG2);
  localparam int unsigned FILL_W = WINDOW_LOG2 + 1;
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE + 1);

  localparam logic [FILL_W-1:0]        WINDOW_DEPTH = FILL_W'(1 << WINDOW_LOG2);
  localparam logic [CNT_W-1:0]         DEB_MAX      = CNT_W'(DEBOUNCE);
  localparam logic [DATA_WIDTH-1:0]    NEAR_T       = DATA_WIDTH'(NEAR_THRESH);
  localparam logic [DATA_WIDTH-1:0]    FAR_T        = DATA_WIDTH'(FAR_THRESH);
  localparam logic [TIMEOUT_WIDTH-1:0] WD_MAX       = '1;

  filter_state_e          state_q, state_d;
  logic [SUM_W-1:0]       sum_q, sum_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic [DATA_WIDTH-1:0]  avg_q, avg_d;
  logic                   avg_valid_q, avg_valid_d;
  logic [CNT_W-1:0]       near_q, near_d;
  logic [CNT_W-1:0]       far_q, far_d;
  logic                   present_q, present_d;
  logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;

  logic                   flush;
  logic [DATA_WIDTH-1:0]  oldest;
  logic [SUM_W-1:0]       sum_upd;
  logic [FILL_W-1:0]      fill_inc;

  window_delay_line #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (WINDOW_LOG2)
  ) u_window (
    .clk     (clk),
    .reset   (reset),
    .push    (sample_valid),
    .clear   (flush),
    .data_in (sample_in),
    .oldest  (oldest)
  );

  // Watchdog; a sample on the would-saturate cycle wins, so flush never fires then.
  always_comb begin
    wd_d  = wd_q;
    flush = 1'b0;
    if (sample_valid) begin
      wd_d = '0;
    end else if (wd_q != WD_MAX) begin
      wd_d  = wd_q + TIMEOUT_WIDTH'(1);
      flush = (wd_q == WD_MAX - TIMEOUT_WIDTH'(1));
    end
  end

  // Empty slots read as zero during FILL, so one update formula serves both states.
  always_comb begin
    sum_upd     = sum_q + SUM_W'(sample_in) - SUM_W'(oldest);
    fill_inc    = fill_q + FILL_W'(1);
    state_d     = state_q;
    sum_d       = sum_q;
    fill_d      = fill_q;
    avg_d       = avg_q;
    avg_valid_d = 1'b0;
    if (flush) begin
      state_d = FILL;
      sum_d   = '0;
      fill_d  = '0;
    end else if (sample_valid) begin
      sum_d = sum_upd;
      unique case (state_q)
        FILL: begin
          fill_d = fill_inc;
          if (fill_inc == WINDOW_DEPTH) begin
            state_d     = RUN;
            avg_valid_d = 1'b1;
            avg_d       = sum_upd[SUM_W-1:WINDOW_LOG2];
          end
        end
        RUN: begin
          avg_valid_d = 1'b1;
          avg_d       = sum_upd[SUM_W-1:WINDOW_LOG2];
        end
      endcase
    end
  end

  // Presence reacts to the registered average, one cycle after avg_valid.
  always_comb begin
    near_d    = near_q;
    far_d     = far_q;
    present_d = present_q;
    if (flush) begin
      near_d    = '0;
      far_d     = '0;
      present_d = 1'b0;
    end else if (avg_valid_q) begin
      if (avg_q < NEAR_T) begin
        far_d  = '0;
        near_d = (near_q == DEB_MAX) ? near_q : near_q + CNT_W'(1);
        if (near_d == DEB_MAX) present_d = 1'b1;
      end else if (avg_q > FAR_T) begin
        near_d = '0;
        far_d  = (far_q == DEB_MAX) ? far_q : far_q + CNT_W'(1);
        if (far_d == DEB_MAX) present_d = 1'b0;
      end else begin
        near_d = '0;
        far_d  = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; combinational
  // blocks above use blocking ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      sum_q       <= '0;
      fill_q      <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      near_q      <= '0;
      far_q       <= '0;
      present_q   <= 1'b0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      fill_q      <= fill_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      near_q      <= near_d;
      far_q       <= far_d;
      present_q   <= present_d;
      wd_q        <= wd_d;
    end
  end

  assign avg_out   = avg_q;
  assign avg_valid = avg_valid_q;
  assign present   = present_q;
  assign stale     = (wd_q == WD_MAX);

endmodule
